gps_ca_multi: RTL and testbench

- Parametrised multi-channel GPS C/A Gold-code generator and capture engine.
- Replaces the single-SV, two-clock C/A path with one clock plus a chip-rate enable divider.
- Generates NUM_CH independent PRN sequences (SV 1..32) in lockstep and captures CAP_LEN chips per channel.
- Feeds the capture registers to the downstream P/L-code and AES stages through a start/busy/done handshake.

---
 rtl/gps_ca_multi.sv | 211 +++++++++++++++++++++
 tb/tb_gps_ca_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gps_ca_multi.sv
// gps_ca_multi
//   Multi-channel GPS C/A Gold-code generator and capture engine. NUM_CH
//   channels run their G1/G2 LFSR pairs in lockstep on a shared chip-rate
//   enable derived from the system clock. Each round captures CAP_LEN chips
//   per channel for downstream P/L-code and AES stages.
//
//   Optional feature macro: GPS_CA_SVERR_EN (adds sv_err; enabled channels
//   with an invalid SV capture zeros instead of the G1-only sequence).
//
// Ports
//   sys_clk_50  in   system clock
//   rst_n_in    in   asynchronous active-low reset
//   start       in   level; a rising edge seen in IDLE launches a round
//   sv_num      in   6 bits per channel, channel i at [6i+5:6i]
//   ch_en       in   per-channel enable, latched at launch
//   busy        out  high in LOAD and RUN
//   done        out  one-cycle completion pulse
//   code_valid  out  high from completion until the next launch
//   ca_code     out  CAP_LEN chips per channel, first chip in the MSB
//   sv_err      out  (GPS_CA_SVERR_EN only) enabled channel with SV 0 or >32
module gps_ca_multi #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CAP_LEN = 13,
   parameter int unsigned CLK_DIV = 1
) (
   input  logic                      sys_clk_50,
   input  logic                      rst_n_in,
   input  logic                      start,
   input  logic [6*NUM_CH-1:0]       sv_num,
   input  logic [NUM_CH-1:0]         ch_en,
   output logic                      busy,
   output logic                      done,
   output logic                      code_valid,
   output logic [CAP_LEN*NUM_CH-1:0] ca_code
`ifdef GPS_CA_SVERR_EN
   ,
   output logic [NUM_CH-1:0]         sv_err
`endif
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(CAP_LEN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t               state, next_state;
   logic                 start_r;
   logic [DIV_W-1:0]     div_cnt;
   logic [CNT_W-1:0]     chip_cnt;
   logic                 tick;
   logic [6*NUM_CH-1:0]  sv_lat;
   logic [NUM_CH-1:0]    en_lat;
   logic [NUM_CH-1:0]    en_eff;
   logic [NUM_CH-1:0]    chip;
   logic [1:10]          g1 [NUM_CH];
   logic [1:10]          g2 [NUM_CH];
   logic [CAP_LEN-1:0]   cap [NUM_CH];

   // G2 phase-select taps; invalid SVs select the same stage twice so the
   // G2 contribution cancels and the chip is G1 stage 10 alone.
   function automatic logic [7:0] sv_taps(input logic [5:0] sv);
      logic [7:0] t;
      case (sv)
         6'd1:  t = {4'd2, 4'd6};
         6'd2:  t = {4'd3, 4'd7};
         6'd3:  t = {4'd4, 4'd8};
         6'd4:  t = {4'd5, 4'd9};
         6'd5:  t = {4'd1, 4'd9};
         6'd6:  t = {4'd2, 4'd10};
         6'd7:  t = {4'd1, 4'd8};
         6'd8:  t = {4'd2, 4'd9};
         6'd9:  t = {4'd3, 4'd10};
         6'd10: t = {4'd2, 4'd3};
         6'd11: t = {4'd3, 4'd4};
         6'd12: t = {4'd5, 4'd6};
         6'd13: t = {4'd6, 4'd7};
         6'd14: t = {4'd7, 4'd8};
         6'd15: t = {4'd8, 4'd9};
         6'd16: t = {4'd9, 4'd10};
         6'd17: t = {4'd1, 4'd4};
         6'd18: t = {4'd2, 4'd5};
         6'd19: t = {4'd3, 4'd6};
         6'd20: t = {4'd4, 4'd7};
         6'd21: t = {4'd5, 4'd8};
         6'd22: t = {4'd6, 4'd9};
         6'd23: t = {4'd1, 4'd3};
         6'd24: t = {4'd4, 4'd6};
         6'd25: t = {4'd5, 4'd7};
         6'd26: t = {4'd6, 4'd8};
         6'd27: t = {4'd7, 4'd9};
         6'd28: t = {4'd8, 4'd10};
         6'd29: t = {4'd1, 4'd6};
         6'd30: t = {4'd2, 4'd7};
         6'd31: t = {4'd3, 4'd8};
         6'd32: t = {4'd4, 4'd9};
         default: t = {4'd1, 4'd1};
      endcase
      return t;
   endfunction

   function automatic logic chip_of(input logic [1:10] g1v, input logic [1:10] g2v,
                                    input logic [5:0] sv);
      logic [7:0] t;
      t = sv_taps(sv);
      return g1v[10] ^ g2v[t[7:4]] ^ g2v[t[3:0]];
   endfunction

   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign busy = (state == LOAD) || (state == RUN);
   assign done = (state == DONE);

`ifdef GPS_CA_SVERR_EN
   logic [NUM_CH-1:0] sv_bad;
   always_comb begin
      sv_bad = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         sv_bad[i] = (sv_lat[6*i +: 6] == 6'd0) || (sv_lat[6*i +: 6] > 6'd32);
   end
   assign en_eff = en_lat & ~sv_bad;
`else
   assign en_eff = en_lat;
`endif

   always_comb begin
      chip = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         chip[i] = chip_of(g1[i], g2[i], sv_lat[6*i +: 6]);
   end

   always_comb begin
      ca_code = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         ca_code[CAP_LEN*i +: CAP_LEN] = cap[i];
   end

   always_ff @(posedge sys_clk_50 or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start && !start_r) next_state = LOAD;
         LOAD:    next_state = RUN;
         RUN:     if (tick && (chip_cnt == CNT_W'(CAP_LEN - 1))) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_50 or negedge rst_n_in) begin
      if (!rst_n_in) begin
         start_r    <= 1'b0;
         div_cnt    <= '0;
         chip_cnt   <= '0;
         code_valid <= 1'b0;
         sv_lat     <= '0;
         en_lat     <= '0;
`ifdef GPS_CA_SVERR_EN
         sv_err     <= '0;
`endif
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            g1[i]  <= '1;
            g2[i]  <= '1;
            cap[i] <= '0;
         end
      end else begin
         // Tracks start in every state so a held level never relaunches.
         start_r <= start;
         case (state)
            IDLE: begin
               if (next_state == LOAD) begin
                  sv_lat     <= sv_num;
                  en_lat     <= ch_en;
                  code_valid <= 1'b0;
               end
            end
            LOAD: begin
               div_cnt  <= '0;
               chip_cnt <= '0;
`ifdef GPS_CA_SVERR_EN
               sv_err   <= en_lat & sv_bad;
`endif
               for (int unsigned i = 0; i < NUM_CH; i++) begin
                  g1[i]  <= '1;
                  g2[i]  <= '1;
                  cap[i] <= '0;
               end
            end
            RUN: begin
               if (tick) begin
                  div_cnt  <= '0;
                  chip_cnt <= chip_cnt + CNT_W'(1);
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     g1[i] <= {g1[i][3] ^ g1[i][10], g1[i][1:9]};
                     g2[i] <= {g2[i][2] ^ g2[i][3] ^ g2[i][6] ^ g2[i][8] ^ g2[i][9] ^ g2[i][10],
                               g2[i][1:9]};
                     cap[i] <= en_eff[i] ? ((cap[i] << 1) | CAP_LEN'(chip[i])) : '0;
                  end
                  if (next_state == DONE) code_valid <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gps_ca_multi.sv
// tb_gps_ca_multi
//   Directed bench for gps_ca_multi: two instances (CLK_DIV=1 and CLK_DIV=4,
//   CAP_LEN=10, NUM_CH=4) share reset, sv_num and ch_en; each has its own
//   start. Expected codes are the published first ten chips of PRN 1..4.
module tb_gps_ca_multi;

   localparam int unsigned NCH = 4;
   localparam int unsigned CL  = 10;

   localparam logic [CL-1:0] PRN1 = 10'b1100100000;
   localparam logic [CL-1:0] PRN2 = 10'b1110010000;
   localparam logic [CL-1:0] PRN3 = 10'b1111001000;
   localparam logic [CL-1:0] PRN4 = 10'b1111100100;
   localparam logic [CL-1:0] G1P  = 10'b1111111111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start4 = 1'b0;
   logic [6*NCH-1:0] sv_num = '0;
   logic [NCH-1:0]   ch_en = '0;

   logic busy1, done1, valid1, busy4, done4, valid4;
   logic [CL*NCH-1:0] code1, code4;
`ifdef GPS_CA_SVERR_EN
   logic [NCH-1:0] sv_err1, sv_err4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gps_ca_multi #(.NUM_CH(NCH), .CAP_LEN(CL), .CLK_DIV(1)) u_dut1 (
      .sys_clk_50(clk), .rst_n_in(rst_n), .start(start1), .sv_num(sv_num),
      .ch_en(ch_en), .busy(busy1), .done(done1), .code_valid(valid1),
      .ca_code(code1)
`ifdef GPS_CA_SVERR_EN
      , .sv_err(sv_err1)
`endif
   );

   gps_ca_multi #(.NUM_CH(NCH), .CAP_LEN(CL), .CLK_DIV(4)) u_dut4 (
      .sys_clk_50(clk), .rst_n_in(rst_n), .start(start4), .sv_num(sv_num),
      .ch_en(ch_en), .busy(busy4), .done(done4), .code_valid(valid4),
      .ca_code(code4)
`ifdef GPS_CA_SVERR_EN
      , .sv_err(sv_err4)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_start(input bit use4, input logic v);
      if (use4) start4 = v;
      else      start1 = v;
   endtask

   // Raises start just after a clock edge so the following edge (cycle T)
   // sees the rising edge. lat is the index i of the post-edge sample in
   // which done is first seen, i=0 being the sample after edge T.
   task automatic run_round(input bit use4, input bit hold, input int poke_at,
                            input int tog_at, input int abort_at,
                            output int lat, output int nbusy, output int nvalid);
      lat = -1; nbusy = 0; nvalid = 0;
      @(posedge clk); #1;
      set_start(use4, 1'b1);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (use4 ? busy4 : busy1) begin
            nbusy++;
            if (use4 ? valid4 : valid1) nvalid++;
         end
         if (i == 0 && !hold) set_start(use4, 1'b0);
         if (i == poke_at) begin
            sv_num = {6'd1, 6'd1, 6'd1, 6'd1};
            ch_en  = '1;
         end
         if (i == tog_at)     set_start(use4, 1'b1);
         if (i == tog_at + 1) set_start(use4, 1'b0);
         if (i == abort_at) begin
            rst_n = 1'b0;
            lat = -2;
            break;
         end
         if (use4 ? done4 : done1) begin
            lat = i;
            break;
         end
      end
   endtask

   int lat, nb, nv, cnt_busy, cnt_done;

   initial begin
      #1;
      check("rst_busy",  busy1,  1'b0);
      check("rst_done",  done1,  1'b0);
      check("rst_valid", valid1, 1'b0);
      check("rst_code",  code1,  '0);
      @(negedge clk); rst_n = 1'b1;

      // Single launch, CLK_DIV=1
      sv_num = {6'd4, 6'd3, 6'd2, 6'd1};
      ch_en  = 4'hF;
      run_round(1'b0, 1'b0, -100, -100, -100, lat, nb, nv);
      check("lat_div1",   lat,    11);
      check("code_div1",  code1,  {PRN4, PRN3, PRN2, PRN1});
      check("valid_done", valid1, 1'b1);
      check("busy_div1",  nb,     11);
      @(posedge clk); #1;
      check("done_pulse", done1,  1'b0);
      check("valid_hold", valid1, 1'b1);

      // Divider, CLK_DIV=4: 1 LOAD cycle + 40 RUN cycles
      run_round(1'b1, 1'b0, -100, -100, -100, lat, nb, nv);
      check("lat_div4",  lat,   41);
      check("busy_div4", nb,    41);
      check("code_div4", code4, {PRN4, PRN3, PRN2, PRN1});

      // Enable mask with sv_num/ch_en changed mid-RUN
      ch_en = 4'b0101;
      run_round(1'b0, 1'b0, 5, -100, -100, lat, nb, nv);
      check("lat_mask",  lat,   11);
      check("code_mask", code1, {10'd0, PRN3, 10'd0, PRN1});
      sv_num = {6'd4, 6'd3, 6'd2, 6'd1};
      ch_en  = 4'hF;

      // start held high through done: exactly one round
      run_round(1'b0, 1'b1, -100, -100, -100, lat, nb, nv);
      check("lat_hold", lat, 11);
      cnt_busy = 0; cnt_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy1) cnt_busy++;
         if (done1) cnt_done++;
      end
      check("hold_norelaunch_busy", cnt_busy, 0);
      check("hold_norelaunch_done", cnt_done, 0);
      start1 = 1'b0;

      // start toggled during RUN is ignored
      run_round(1'b0, 1'b0, -100, 4, -100, lat, nb, nv);
      check("lat_tog",  lat,   11);
      check("code_tog", code1, {PRN4, PRN3, PRN2, PRN1});
      // Relaunch on the IDLE cycle right after DONE
      run_round(1'b0, 1'b0, -100, -100, -100, lat, nb, nv);
      check("lat_relaunch",   lat,   11);
      check("busy_relaunch",  nb,    11);
      check("valid_in_round", nv,    0);
      check("code_relaunch",  code1, {PRN4, PRN3, PRN2, PRN1});

      // Async reset mid-RUN (chip 5)
      run_round(1'b0, 1'b0, -100, -100, 6, lat, nb, nv);
      check("abort_reached", lat, -2);
      #1;
      check("abort_busy",  busy1,  1'b0);
      check("abort_done",  done1,  1'b0);
      check("abort_valid", valid1, 1'b0);
      check("abort_code",  code1,  '0);
      @(negedge clk); rst_n = 1'b1;
      cnt_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done1) cnt_done++;
      end
      check("abort_nodone", cnt_done, 0);
      run_round(1'b0, 1'b0, -100, -100, -100, lat, nb, nv);
      check("lat_after_abort",  lat,   11);
      check("code_after_abort", code1, {PRN4, PRN3, PRN2, PRN1});

      // Invalid SVs: ch1 = 0, ch2 = 40
      sv_num = {6'd4, 6'd40, 6'd0, 6'd1};
      run_round(1'b0, 1'b0, -100, -100, -100, lat, nb, nv);
      check("lat_badsv", lat, 11);
`ifdef GPS_CA_SVERR_EN
      check("sv_err",     sv_err1, 4'b0110);
      check("code_badsv", code1,   {PRN4, 10'd0, 10'd0, PRN1});
`else
      check("code_badsv", code1,   {PRN4, G1P, G1P, PRN1});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
